// File: rtl/mcla_pipe_adder_if.sv
// Operand/result handshake bundle for mcla_pipe_adder: valid/ready on both sides.
// The adder uses the slave modport; the producer/consumer side uses master.
interface mcla_pipe_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             approx_en;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   s;

    modport master (
        output in_valid, a, b, cin, approx_en, out_ready,
        input  in_ready, out_valid, s
    );

    modport slave (
        input  in_valid, a, b, cin, approx_en, out_ready,
        output in_ready, out_valid, s
    );
endinterface

// File: rtl/mcla_pipe_adder.sv
// Pipelined adder of 4-bit carry-lookahead groups with an optional approximate (OR-based) low part.
// Latency (WIDTH/4)/STAGE_GROUPS cycles; stages hold in place while out_ready=0, in_ready drops when stage 0 cannot advance.
module mcla_pipe_adder #(
    parameter int WIDTH        = 16,
    parameter int STAGE_GROUPS = 2,
    parameter int APPROX_BITS  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mcla_pipe_adder_if.slave  ifc
);

    localparam int NGRP  = WIDTH / 4;
    localparam int L     = NGRP / STAGE_GROUPS;
    localparam int SBITS = STAGE_GROUPS * 4;
    localparam int ATOP  = (APPROX_BITS > 0) ? APPROX_BITS - 1 : 0;

    function automatic logic [WIDTH-1:0] approx_mask();
        logic [WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i < APPROX_BITS) m[i] = 1'b1;
        end
        return m;
    endfunction

    localparam logic [WIDTH-1:0] AMASK = approx_mask();

    // Two-level lookahead: every internal carry is a flat sum of products of g/p and c0.
    function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic c0);
        logic [3:0] g;
        logic [3:0] p;
        logic       c1;
        logic       c2;
        logic       c3;
        logic       c4;
        g  = x & y;
        p  = x ^ y;
        c1 = g[0] | (p[0] & c0);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                  | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c4, p ^ {c3, c2, c1, c0}};
    endfunction

    if ((WIDTH % 4) != 0 || WIDTH < 4 || WIDTH > 64 || STAGE_GROUPS < 1 ||
        (NGRP % STAGE_GROUPS) != 0 || APPROX_BITS < 0 || APPROX_BITS > WIDTH) begin : g_param_check
        $error("mcla_pipe_adder: illegal parameter combination");
    end

    logic [WIDTH-1:0] pre_a;
    logic [WIDTH-1:0] pre_b;
    logic [WIDTH-1:0] pre_sum;
    logic             pre_c;

    logic [WIDTH-1:0] src_a   [L];
    logic [WIDTH-1:0] src_b   [L];
    logic [WIDTH-1:0] src_sum [L];
    logic [WIDTH-1:0] nxt_sum [L];
    logic [L-1:0]     src_c;
    logic [L-1:0]     nxt_c;

    logic [WIDTH-1:0] st_a    [L];
    logic [WIDTH-1:0] st_b    [L];
    logic [WIDTH-1:0] st_sum  [L];
    logic [L-1:0]     st_c;
    logic [L-1:0]     st_vld;

    logic [L-1:0]     adv;
    logic [L-1:0]     load;
    logic             down;
    logic             in_fire;

    // Approx mode zeroes the low operand bits so the adder produces zeros there and
    // no carry, except the top approx bit where a&b on both operands yields exactly
    // carry = a&b; the OR result is then merged into the sum bits.
    always_comb begin
        pre_a   = ifc.a;
        pre_b   = ifc.b;
        pre_sum = '0;
        pre_c   = ifc.cin;
        if (ifc.approx_en) begin
            pre_c   = 1'b0;
            pre_a   = ifc.a & ~AMASK;
            pre_b   = ifc.b & ~AMASK;
            pre_sum = (ifc.a | ifc.b) & AMASK;
            if (APPROX_BITS > 0) begin
                pre_a[ATOP] = ifc.a[ATOP] & ifc.b[ATOP];
                pre_b[ATOP] = ifc.a[ATOP] & ifc.b[ATOP];
            end
        end
    end

    for (genvar k = 0; k < L; k++) begin : g_stage
        logic [STAGE_GROUPS:0] chain;
        logic [SBITS-1:0]      grp_sum;

        if (k == 0) begin : g_head
            assign src_a[k]   = pre_a;
            assign src_b[k]   = pre_b;
            assign src_sum[k] = pre_sum;
            assign src_c[k]   = pre_c;
        end else begin : g_body
            assign src_a[k]   = st_a[k-1];
            assign src_b[k]   = st_b[k-1];
            assign src_sum[k] = st_sum[k-1];
            assign src_c[k]   = st_c[k-1];
        end

        assign chain[0] = src_c[k];

        for (genvar j = 0; j < STAGE_GROUPS; j++) begin : g_grp
            localparam int G = k * STAGE_GROUPS + j;
            logic [4:0] r;
            assign r                  = cla4(src_a[k][G*4 +: 4], src_b[k][G*4 +: 4], chain[j]);
            assign chain[j+1]         = r[4];
            assign grp_sum[j*4 +: 4]  = r[3:0];
        end

        assign nxt_sum[k] = src_sum[k] | (WIDTH'(grp_sum) << (k * SBITS));
        assign nxt_c[k]   = chain[STAGE_GROUPS];
    end

    // Walk back from the output: a stage may move if the one after it is empty or moving.
    always_comb begin
        adv  = '0;
        down = ifc.out_ready;
        for (int k = L - 1; k >= 0; k--) begin
            adv[k] = st_vld[k] & down;
            down   = ~st_vld[k] | adv[k];
        end
    end

    assign ifc.in_ready = rst_n & down;
    assign in_fire      = ifc.in_valid & ifc.in_ready;

    always_comb begin
        load    = '0;
        load[0] = in_fire;
        for (int k = 1; k < L; k++) begin
            load[k] = adv[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_vld <= '0;
        end else begin
            for (int k = 0; k < L; k++) begin
                if (load[k]) begin
                    st_vld[k] <= 1'b1;
                end else if (adv[k]) begin
                    st_vld[k] <= 1'b0;
                end
            end
        end
    end

    // Only the output stage is cleared so s reads zero after reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < L; k++) begin
            if (load[k]) begin
                st_a[k]   <= src_a[k];
                st_b[k]   <= src_b[k];
                st_sum[k] <= nxt_sum[k];
                st_c[k]   <= nxt_c[k];
            end
        end
        if (!rst_n) begin
            st_sum[L-1] <= '0;
            st_c[L-1]   <= 1'b0;
        end
    end

    assign ifc.out_valid = st_vld[L-1];
    assign ifc.s         = {st_c[L-1], st_sum[L-1]};

endmodule

// File: tb/tb_mcla_pipe_adder.sv
// Directed self-checking bench for mcla_pipe_adder (WIDTH=16, STAGE_GROUPS=2, APPROX_BITS=4, two-stage pipe).
module tb_mcla_pipe_adder;

    localparam int W = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mcla_pipe_adder_if #(.WIDTH(W)) ifc ();

    mcla_pipe_adder #(
        .WIDTH        (W),
        .STAGE_GROUPS (2),
        .APPROX_BITS  (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ifc   (ifc)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [15:0] tv_a [14];
    logic [15:0] tv_b [14];
    logic        tv_c [14];
    logic        tv_x [14];
    logic [16:0] tv_s [14];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int i, input logic [15:0] a, input logic [15:0] b,
                           input logic c, input logic x, input logic [16:0] s);
        tv_a[i] = a;
        tv_b[i] = b;
        tv_c[i] = c;
        tv_x[i] = x;
        tv_s[i] = s;
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic c, input logic x);
        ifc.a         = a;
        ifc.b         = b;
        ifc.cin       = c;
        ifc.approx_en = x;
    endtask

    task automatic single(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic c, input logic x, input logic [16:0] exp);
        drive(a, b, c, x);
        ifc.in_valid  = 1'b1;
        ifc.out_ready = 1'b1;
        #1;
        check({tag, "_rdy"}, ifc.in_ready, 1);
        step();
        ifc.in_valid = 1'b0;
        check({tag, "_t1"}, ifc.out_valid, 0);
        step();
        check({tag, "_vld"}, ifc.out_valid, 1);
        check({tag, "_s"}, ifc.s, exp);
        step();
    endtask

    // Streams table entries base..base+n-1; stall bit c forces out_ready=0 in cycle c.
    task automatic run_stream(input string tag, input int base, input int n,
                              input logic [31:0] stall, input bit tput);
        int          sent    = 0;
        int          got     = 0;
        int          cyc     = 0;
        int          first   = -1;
        int          last    = -1;
        int          inflight;
        bit          holding = 1'b0;
        logic [16:0] held    = '0;
        logic        exp_rdy;
        while (got < n && cyc < 32) begin
            ifc.in_valid = (sent < n);
            if (sent < n) drive(tv_a[base+sent], tv_b[base+sent], tv_c[base+sent], tv_x[base+sent]);
            ifc.out_ready = ~stall[cyc];
            #1;
            if (holding) begin
                check({tag, "_hold_vld"}, ifc.out_valid, 1);
                check({tag, "_hold_s"}, ifc.s, held);
            end
            inflight = sent - got;
            exp_rdy  = !(inflight == 2 && !ifc.out_ready);
            check({tag, "_in_ready"}, ifc.in_ready, exp_rdy);
            if (ifc.out_valid && ifc.out_ready) begin
                check({tag, "_s"}, ifc.s, tv_s[base+got]);
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
            holding = ifc.out_valid && !ifc.out_ready;
            held    = ifc.s;
            if (ifc.in_valid && ifc.in_ready) sent++;
            step();
            cyc++;
        end
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b1;
        check({tag, "_count"}, got, n);
        if (tput) begin
            check({tag, "_first"}, first, 2);
            check({tag, "_span"}, last - first, n - 1);
        end
        for (int i = 0; i < 3; i++) begin
            check({tag, "_drain"}, ifc.out_valid, 0);
            step();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        set_vec(0,  16'h0001, 16'h0001, 1'b0, 1'b0, 17'h00002);
        set_vec(1,  16'h0008, 16'h0008, 1'b0, 1'b1, 17'h00018);
        set_vec(2,  16'h00FF, 16'h0001, 1'b1, 1'b0, 17'h00101);
        set_vec(3,  16'h00FF, 16'h0001, 1'b1, 1'b1, 17'h000FF);
        set_vec(4,  16'h8000, 16'h8000, 1'b0, 1'b0, 17'h10000);
        set_vec(5,  16'hFFF7, 16'h0008, 1'b0, 1'b1, 17'h0FFFF);
        set_vec(6,  16'hABCD, 16'h1111, 1'b0, 1'b0, 17'h0BCDE);
        set_vec(7,  16'hFFFF, 16'h000F, 1'b0, 1'b1, 17'h1000F);
        set_vec(8,  16'h0010, 16'h0001, 1'b0, 1'b0, 17'h00011);
        set_vec(9,  16'h0100, 16'h0002, 1'b0, 1'b0, 17'h00102);
        set_vec(10, 16'h1000, 16'h0003, 1'b0, 1'b0, 17'h01003);
        set_vec(11, 16'h0F00, 16'h0100, 1'b0, 1'b0, 17'h01000);
        set_vec(12, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 17'h1FFFE);
        set_vec(13, 16'h7FFF, 16'h0001, 1'b0, 1'b1, 17'h07FFF);

        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b1;
        drive(16'h0000, 16'h0000, 1'b0, 1'b0);
        rst_n = 1'b0;
        step();
        step();
        check("rst_out_valid", ifc.out_valid, 0);
        check("rst_s", ifc.s, 0);
        check("rst_in_ready", ifc.in_ready, 0);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", ifc.in_ready, 1);

        single("carry_chain", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h10000);
        single("cin_small",   16'h1234, 16'h4321, 1'b1, 1'b0, 17'h05556);
        single("cin_max",     16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 17'h1FFFF);
        single("approx_gen",  16'h0008, 16'h0008, 1'b0, 1'b1, 17'h00018);
        single("approx_cin",  16'h000F, 16'h0001, 1'b1, 1'b1, 17'h0000F);

        run_stream("tput", 0, 8, 32'h0000_0000, 1'b1);
        run_stream("bp",   8, 6, 32'h0000_003C, 1'b0);

        // Two transactions in flight, then a one-cycle reset discards them.
        ifc.out_ready = 1'b0;
        drive(tv_a[0], tv_b[0], tv_c[0], tv_x[0]);
        ifc.in_valid = 1'b1;
        step();
        drive(tv_a[2], tv_b[2], tv_c[2], tv_x[2]);
        step();
        rst_n = 1'b0;
        drive(tv_a[4], tv_b[4], tv_c[4], tv_x[4]);
        #1;
        check("mid_rst_in_ready", ifc.in_ready, 0);
        check("mid_rst_pre_vld", ifc.out_valid, 1);
        step();
        rst_n         = 1'b1;
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b1;
        #1;
        check("mid_rst_out_valid", ifc.out_valid, 0);
        check("mid_rst_s", ifc.s, 0);
        check("mid_rst_in_ready_after", ifc.in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("mid_rst_no_ghost", ifc.out_valid, 0);
        end

        single("post_rst", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 17'h01000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mcla_pipe_adder.md
MCLA_PIPE_ADDER -- requirements
Module: mcla_pipe_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand width; SHALL be a multiple of 4, range 4..64.
REQ-002 Parameter STAGE_GROUPS, default 2: 4-bit lookahead groups resolved per pipeline stage; SHALL divide WIDTH/4.
REQ-003 Parameter APPROX_BITS, default 4: low bits handled by approximate lower-part logic when approx mode is selected; range 0..WIDTH.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  1  operand transaction offered.
REQ-007 in_ready  output  1  block accepts the offered transaction this cycle.
REQ-008 a  input  WIDTH  operand A, unsigned.
REQ-009 b  input  WIDTH  operand B, unsigned.
REQ-010 cin  input  1  carry-in, exact mode only.
REQ-011 approx_en  input  1  1 = approximate mode for this transaction.
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  downstream accepts result.
REQ-014 s  output  WIDTH+1  sum; MSB is carry-out.

Function
REQ-015 Transfer occurs on a cycle where in_valid=1 and in_ready=1 (input), or out_valid=1 and out_ready=1 (output).
REQ-016 a, b, cin and approx_en SHALL be captured together at input transfer; approx_en is per-transaction and travels with it.
REQ-017 Exact mode: s = a + b + cin, full WIDTH+1 bits, no loss.
REQ-018 Approx mode: s[APPROX_BITS-1:0] = a | b bitwise; carry into bit APPROX_BITS = a[APPROX_BITS-1] & b[APPROX_BITS-1]; cin ignored; upper bits exact sum with that carry; APPROX_BITS=0 makes approx mode equal exact mode with cin forced 0.
REQ-019 Each 4-bit group SHALL compute generate/propagate per bit and all four internal carries by two-level lookahead from the group carry-in; no intra-group ripple.
REQ-020 Pipeline depth L = (WIDTH/4)/STAGE_GROUPS stages; stage k resolves groups k*STAGE_GROUPS..(k+1)*STAGE_GROUPS-1, group carry passing between groups within a stage, registered between stages.
REQ-021 Unresolved upper operand bits and already-resolved sum bits SHALL be carried in stage registers alongside the stage carry.
REQ-022 Latency: result of a transaction accepted at cycle t is presented on s with out_valid=1 at cycle t+L when not stalled.
REQ-023 Each stage holds one valid bit; stage advances when its successor is empty or advancing in the same cycle; last stage advances on output transfer.
REQ-024 in_ready = rst_n AND (stage 0 empty OR stage 0 advancing); combinational from state and out_ready, never from in_valid.
REQ-025 Throughput: one transaction per cycle while out_ready=1; no bubbles inserted.
REQ-026 Stall: while out_valid=1 and out_ready=0, s and all occupied stage contents SHALL hold unchanged; at most L transactions in flight, none lost or duplicated, order preserved.
REQ-027 Simultaneous input and output transfer on a full pipeline SHALL be accepted (pipeline stays full).
REQ-028 in_valid=0 cycles SHALL create empty stages that propagate as bubbles; out_valid=0 for those slots.

Reset
REQ-029 rst_n=0 at a rising edge SHALL clear all stage valid bits, out_valid=0, s=0, regardless of in-flight transactions (discarded).
REQ-030 While rst_n=0, in_ready=0 and input transfers SHALL NOT occur; first acceptance possible in the cycle after rst_n returns to 1.
REQ-031 Datapath registers other than s and valid bits need no reset.

Verification (WIDTH=16, STAGE_GROUPS=2, APPROX_BITS=4, L=2)
REQ-032 Carry-chain: a=0xFFFF, b=0x0001, cin=0, exact -> s=0x10000, out_valid at t+2.
REQ-033 Carry-in: a=0x1234, b=0x4321, cin=1, exact -> s=0x05556; a=0xFFFF, b=0xFFFF, cin=1 -> s=0x1FFFF.
REQ-034 Approx: a=0x0008, b=0x0008, approx_en=1 -> s=0x00018 (exact would give 0x00010); a=0x000F, b=0x0001, cin=1, approx_en=1 -> s=0x0000F.
REQ-035 Backpressure: 6 back-to-back inputs, out_ready=0 for cycles 2..5 -> in_ready=0 once 2 in flight, s held stable, all 6 results delivered in order, none repeated.
REQ-036 Throughput: out_ready=1, 8 consecutive inputs mixing approx_en 0/1 -> out_valid high 8 consecutive cycles starting t+2, each result per its own mode.
REQ-037 Reset mid-operation: rst_n=0 one cycle with 2 transactions in flight -> next cycle out_valid=0, s=0, in_ready=0 during reset, 1 after; discarded results never appear.
